// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out receiver: hunts for a start bit, shifts in a WIDTH-bit word MSB-first
// on i_en strobes and offers it with valid/ready. Define SIPO_PARITY_EN to add an even-parity bit.
module sipo_deframer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_s,
  input  logic             i_en,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_p,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_perr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             complete;
  logic [WIDTH-1:0] word;
`ifdef SIPO_PARITY_EN
  logic             perr_d;
  logic             perr_q;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    word     = sh_q;
`ifdef SIPO_PARITY_EN
    perr_d   = 1'b0;
`endif
    if (i_en) begin
      unique case (state_q)
        IDLE: begin
          if (i_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          sh_d  = {sh_q[WIDTH-2:0], i_s};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            complete = 1'b1;
            word     = sh_d;
`endif
          end
        end
        PARITY: begin
          state_d = IDLE;
`ifdef SIPO_PARITY_EN
          // Even parity: data bits plus parity bit must XOR to zero.
          if (^{sh_q, i_s}) perr_d   = 1'b1;
          else              complete = 1'b1;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output word register with valid/ready handshake and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_p       <= '0;
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end else if (complete) begin
      if (!o_valid || i_ready) begin
        o_p     <= word;
        o_valid <= 1'b1;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
  assign o_perr = perr_q;
`else
  assign o_perr = 1'b0;
`endif

  assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed self-checking bench for sipo_deframer (WIDTH=4); covers the parity build when
// SIPO_PARITY_EN is defined.
module tb_sipo_deframer;

  localparam int WIDTH = 4;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_s = 1'b0;
  logic             i_en = 1'b0;
  logic             i_ready = 1'b0;
  logic [WIDTH-1:0] o_p;
  logic             o_valid;
  logic             o_busy;
  logic             o_overrun;
  logic             o_perr;

  int n_pass = 0;
  int n_total = 0;

  sipo_deframer #(.WIDTH(WIDTH)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_s      (i_s),
    .i_en     (i_en),
    .i_ready  (i_ready),
    .o_p      (o_p),
    .o_valid  (o_valid),
    .o_busy   (o_busy),
    .o_overrun(o_overrun),
    .o_perr   (o_perr)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it before sampling.
  task automatic step(input logic s, input logic en, input logic rdy);
    i_s = s;
    i_en = en;
    i_ready = rdy;
    @(posedge i_clk);
    #1;
  endtask

  // Start bit, data MSB-first, optional parity; i_ready=rdy_last only on the completion edge.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic rdy_last);
    step(1'b1, 1'b1, 1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SIPO_PARITY_EN
      step(w[i], 1'b1, 1'b0);
`else
      step(w[i], 1'b1, (i == 0) ? rdy_last : 1'b0);
`endif
    end
`ifdef SIPO_PARITY_EN
    step(^w, 1'b1, rdy_last);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p"}, 32'(o_p), 32'h0);
    check({tag, "_valid"}, 32'(o_valid), 32'h0);
    check({tag, "_busy"}, 32'(o_busy), 32'h0);
    check({tag, "_overrun"}, 32'(o_overrun), 32'h0);
    check({tag, "_perr"}, 32'(o_perr), 32'h0);
  endtask

  initial begin
    // Reset
    i_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    i_rst = 1'b0;
    check_all_zero("reset");

    // Basic receive: idle zeros ignored, start bit, then 1010
    step(1'b0, 1'b1, 1'b0);
    check("idle0_busy", 32'(o_busy), 32'h0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("start_busy", 32'(o_busy), 32'h1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mid_valid", 32'(o_valid), 32'h0);
    check("mid_busy", 32'(o_busy), 32'h1);
    step(1'b0, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    check("par_wait_busy", 32'(o_busy), 32'h1);
    step(1'b0, 1'b1, 1'b0);
`endif
    check("basic_p", 32'(o_p), 32'ha);
    check("basic_valid", 32'(o_valid), 32'h1);
    check("basic_busy", 32'(o_busy), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("accept_valid", 32'(o_valid), 32'h0);
    check("accept_p", 32'(o_p), 32'ha);
    step(1'b0, 1'b0, 1'b1);
    check("idle_ready_valid", 32'(o_valid), 32'h0);

    // Overrun: second word dropped while first unconsumed
    send_frame(4'b1010, 1'b0);
    check("ovr_first_p", 32'(o_p), 32'ha);
    check("ovr_first_overrun", 32'(o_overrun), 32'h0);
    send_frame(4'b0110, 1'b0);
    check("ovr_p", 32'(o_p), 32'ha);
    check("ovr_valid", 32'(o_valid), 32'h1);
    check("ovr_overrun", 32'(o_overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    check("ovr_sticky", 32'(o_overrun), 32'h1);
    i_rst = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    i_rst = 1'b0;
    check_all_zero("ovr_reset");

    // Simultaneous accept and completion
    send_frame(4'b1010, 1'b0);
    check("sim_first_p", 32'(o_p), 32'ha);
    send_frame(4'b0110, 1'b1);
    check("sim_p", 32'(o_p), 32'h6);
    check("sim_valid", 32'(o_valid), 32'h1);
    check("sim_overrun", 32'(o_overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    check("sim_drain", 32'(o_valid), 32'h0);

    // Gated bits: every enabled edge followed by a gated edge carrying the wrong level
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("gate_busy", 32'(o_busy), 32'h1);
    check("gate_valid_early", 32'(o_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
`endif
    check("gate_p", 32'(o_p), 32'h9);
    check("gate_valid", 32'(o_valid), 32'h1);
    step(1'b0, 1'b0, 1'b1);

    // Mid-frame reset after two data bits, then a clean frame
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    i_rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    i_rst = 1'b0;
    check_all_zero("midrst");
    send_frame(4'b0011, 1'b0);
    check("post_rst_p", 32'(o_p), 32'h3);
    check("post_rst_valid", 32'(o_valid), 32'h1);
    check("post_rst_overrun", 32'(o_overrun), 32'h0);
    step(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    // Good parity then bad parity
    send_frame(4'b1010, 1'b0);
    check("par_good_p", 32'(o_p), 32'ha);
    check("par_good_valid", 32'(o_valid), 32'h1);
    check("par_good_perr", 32'(o_perr), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("par_bad_perr", 32'(o_perr), 32'h1);
    check("par_bad_p", 32'(o_p), 32'ha);
    check("par_bad_valid", 32'(o_valid), 32'h1);
    check("par_bad_overrun", 32'(o_overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0);
    check("par_perr_pulse", 32'(o_perr), 32'h0);
`else
    check("noparity_perr", 32'(o_perr), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sipo_deframer.md
# sipo_deframer

Serial-in/parallel-out receiver: the receiving end of the team's PISO/SISO shift-register link. It hunts for a start bit on a one-bit serial line, shifts in a WIDTH-bit word MSB-first on bit-enable strobes, and presents the word on a parallel output with a valid/ready handshake. It sits between a serial source (a PSISO-style transmitter) and a parallel consumer.

## Interface
Parameters:
- WIDTH, 4, data word width in bits; must be 2 or more.

Ports:
- i_clk  input  1  system clock; all logic is clocked on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_s  input  1  serial data line; idle level 0.
- i_en  input  1  bit strobe; i_s is sampled only on edges where i_en=1.
- i_ready  input  1  consumer accepts o_p on an edge where o_valid=1 and i_ready=1.
- o_p  output  WIDTH  received word; first received bit is o_p[WIDTH-1].
- o_valid  output  1  o_p holds an unconsumed word.
- o_busy  output  1  a frame is in progress (state is not IDLE).
- o_overrun  output  1  sticky flag: a completed word was dropped because the previous word was not yet accepted.
- o_perr  output  1  one-cycle pulse on a parity failure. Tied to 0 when parity is compiled out.

## Operation
- Frame format: start bit (1), then WIDTH data bits MSB-first, then one parity bit only when SIPO_PARITY_EN is defined.
- State machine has three states: IDLE, SHIFT, PARITY.
- IDLE -> SHIFT on an edge with i_en=1 and i_s=1. The bit counter is cleared and the start bit is not stored. While idle, 0s with i_en=1 are ignored.
- SHIFT, on each edge with i_en=1: the shift register updates as sh <= {sh[WIDTH-2:0], i_s}, and the counter increments.
- The data bit sampled when the counter equals WIDTH-1 is the last data bit:
  - Without parity: the word {sh[WIDTH-2:0], i_s} completes and the FSM goes to IDLE.
  - With parity: the FSM goes to PARITY.
- PARITY, on the next edge with i_en=1: the word completes if XOR(data bits, parity bit) = 0, and the FSM goes to IDLE. Otherwise the word is discarded, o_perr pulses for one cycle, and the FSM goes to IDLE.
- Edges with i_en=0 hold all state in every state.
- On word completion:
  - If o_valid=0, or o_valid=1 and i_ready=1 on the same edge: o_p is loaded and o_valid is 1.
  - If o_valid=1 and i_ready=0: the new word is dropped, o_p and o_valid are unchanged, and o_overrun is set to 1.
- An accept without a completion on the same edge clears o_valid. o_p retains its value.
- o_overrun stays 1 until reset.
- A start bit may be accepted on the edge immediately after completion. Back-to-back frames need no gap.

## Timing
- Reset values: o_p=0, o_valid=0, o_busy=0, o_overrun=0, o_perr=0. The shift register and counter are 0 and the state is IDLE.
- Reset mid-frame aborts the frame with no partial word and no flag. Reset overrides i_en and i_ready on the same edge.
- Latency: o_valid and o_p update on the same edge that samples the last data bit (or the parity bit). They are visible in the following cycle.
- With i_en held at 1, a frame spans WIDTH+1 edges without parity and WIDTH+2 with parity. o_busy is high from the edge after the start bit until the completion edge.
- All outputs are registered, with no combinational path from inputs to outputs. o_perr is a registered pulse, high for exactly one cycle.
- i_ready is ignored while o_valid=0.

## Configuration
- SIPO_PARITY_EN defined:
  - The PARITY state, parity check and o_perr pulse are built in.
  - The frame is start bit + WIDTH data bits + even-parity bit.
- SIPO_PARITY_EN undefined:
  - The PARITY state and its logic are removed and o_perr is a constant 0.
  - The frame is start bit + WIDTH data bits, with completion on the last data bit.

## Test plan
All scenarios use WIDTH=4.
- Basic receive (parity off): i_en=1 and i_ready=0. Drive i_s = 0,0,1,1,0,1,0 -> o_busy goes high after the third edge. After the last bit, o_p=4'b1010 and o_valid=1. Then i_ready=1 for one cycle -> o_valid=0 and o_p stays 4'b1010.
- Overrun: keep i_ready=0 and send 1010 then 0110 back-to-back -> o_p stays 4'b1010, o_valid=1, o_overrun=1. Then reset -> all outputs are 0.
- Simultaneous accept and completion: o_valid=1 with 4'b1010. Drive i_ready=1 on the completion edge of 0110 -> o_p=4'b0110, o_valid stays 1, o_overrun=0.
- Gated bits and mid-frame reset: toggle i_en 1/0 through a frame of 1001 -> o_p=4'b1001 after eight enabled-or-gated edges, matching i_en. Then start a new frame with i_rst=1 after two data bits, release reset, and send a full frame of 0011 -> o_p=4'b0011 with no corruption.
- Parity (SIPO_PARITY_EN defined):
  - Send 1, 1010, 0 -> o_p=4'b1010 and o_valid=1.
  - Send 1, 0110, 1 -> o_perr is high for exactly one cycle, o_valid is unchanged, and o_p is not loaded.
